// File: rtl/param_swap_rf_pkg.sv
// rtl/param_swap_rf_pkg.sv - shared types and widths for the swap register file
package param_swap_rf_pkg;

   localparam int STATE_W = 2;
   localparam int CNT_W   = 16;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_MOVE  = 2'd2,
      ST_STORE = 2'd3
   } state_e;

endpackage

// File: rtl/swap_rf_ctrl.sv
// rtl/swap_rf_ctrl.sv - swap FSM, A/B capture, done pulse and optional SWAP_CNT_EN counter
module swap_rf_ctrl
   import param_swap_rf_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_swap_req,
   input  logic [ADDR_W-1:0] i_addr_a,
   input  logic [ADDR_W-1:0] i_addr_b,
   output logic [ADDR_W-1:0] o_addr_a,
   output logic [ADDR_W-1:0] o_addr_b,
   output logic              o_tmp_load,
   output logic              o_sel_a,
   output logic              o_sel_b,
   output logic              o_busy,
   output logic              o_done
`ifdef SWAP_CNT_EN
   ,
   output logic [CNT_W-1:0]  o_count
`endif
);

   state_e            r_state;
   state_e            w_state_nxt;
   logic              w_accept;
   logic [ADDR_W-1:0] r_addr_a;
   logic [ADDR_W-1:0] r_addr_b;
   logic              r_done;

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      o_tmp_load  = 1'b0;
      o_sel_a     = 1'b0;
      o_sel_b     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_swap_req) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            o_tmp_load  = 1'b1;
            w_state_nxt = ST_MOVE;
         end
         ST_MOVE: begin
            o_sel_a     = 1'b1;
            w_state_nxt = ST_STORE;
         end
         ST_STORE: begin
            o_sel_b     = 1'b1;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_addr_a <= '0;
         r_addr_b <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // Addresses are frozen at accept so later A/B changes cannot disturb a swap.
         if (w_accept) begin
            r_addr_a <= i_addr_a;
            r_addr_b <= i_addr_b;
         end
         r_done <= (r_state == ST_STORE);
      end
   end

`ifdef SWAP_CNT_EN
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (r_state == ST_STORE) begin
         r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_count = r_count;
`endif

   assign o_addr_a = r_addr_a;
   assign o_addr_b = r_addr_b;
   assign o_busy   = (r_state != ST_IDLE);
   assign o_done   = r_done;

endmodule

// File: rtl/param_swap_reg_file.sv
// rtl/param_swap_reg_file.sv - register file with write port, async read and hardware swap engine
// Optional feature: SWAP_CNT_EN adds the swap_count output.
module param_swap_reg_file
   import param_swap_rf_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] address_w,
   input  logic [DATA_W-1:0] data_w,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   input  logic              swap_req,
   input  logic [ADDR_W-1:0] address_A,
   input  logic [ADDR_W-1:0] address_B,
   output logic              swap_busy,
   output logic              swap_done
`ifdef SWAP_CNT_EN
   ,
   output logic [CNT_W-1:0]  swap_count
`endif
);

   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_tmp;
   logic [ADDR_W-1:0] w_addr_a;
   logic [ADDR_W-1:0] w_addr_b;
   logic              w_tmp_load;
   logic              w_sel_a;
   logic              w_sel_b;
   logic              w_busy;

   swap_rf_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_ctrl (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_swap_req (swap_req),
      .i_addr_a   (address_A),
      .i_addr_b   (address_B),
      .o_addr_a   (w_addr_a),
      .o_addr_b   (w_addr_b),
      .o_tmp_load (w_tmp_load),
      .o_sel_a    (w_sel_a),
      .o_sel_b    (w_sel_b),
      .o_busy     (w_busy),
      .o_done     (swap_done)
`ifdef SWAP_CNT_EN
      ,
      .o_count    (swap_count)
`endif
   );

   assign wr_ready  = ~w_busy;
   assign swap_busy = w_busy;
   assign rd_data   = r_mem[rd_addr];

   // Host writes only land in IDLE and swap writes only in MOVE/STORE, so they never collide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (we && wr_ready) begin
            r_mem[address_w] <= data_w;
         end
         if (w_sel_a) begin
            r_mem[w_addr_a] <= r_mem[w_addr_b];
         end
         if (w_sel_b) begin
            r_mem[w_addr_b] <= r_tmp;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tmp <= '0;
      end else if (w_tmp_load) begin
         r_tmp <= r_mem[w_addr_a];
      end
   end

endmodule

// File: tb/tb_param_swap_reg_file.sv
// tb/tb_param_swap_reg_file.sv - scoreboard bench for param_swap_reg_file
module tb_param_swap_reg_file;

   logic       clk;
   logic       reset_n;
   logic       we;
   logic [7:0] address_w;
   logic [7:0] data_w;
   logic       wr_ready;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       swap_req;
   logic [7:0] address_A;
   logic [7:0] address_B;
   logic       swap_busy;
   logic       swap_done;
`ifdef SWAP_CNT_EN
   logic [15:0] swap_count;
`endif

   param_swap_reg_file #(
      .DATA_W (8),
      .ADDR_W (8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .we         (we),
      .address_w  (address_w),
      .data_w     (data_w),
      .wr_ready   (wr_ready),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .swap_req   (swap_req),
      .address_A  (address_A),
      .address_B  (address_B),
      .swap_busy  (swap_busy),
      .swap_done  (swap_done)
`ifdef SWAP_CNT_EN
      ,
      .swap_count (swap_count)
`endif
   );

   int         n_pass;
   int         n_total;
   int         cyc;
   int         busy_run;
   int         model_cnt;
   logic       rd_chk;
   logic [7:0] ref_mem [256];
   int         done_q [$];
   logic [7:0] rd_q [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      model_cnt = 0;
   endtask

   task automatic model_swap(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] t;
      t          = ref_mem[a];
      ref_mem[a] = ref_mem[b];
      ref_mem[b] = t;
      model_cnt++;
   endtask

   // Monitor: pops expected responses whenever the DUT presents an output.
   always @(negedge clk) begin
      if (!reset_n) begin
         busy_run = 0;
      end else begin
         if (swap_done) begin
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_cycle", cyc, done_q.pop_front());
         end
         if (swap_busy) begin
            busy_run++;
         end else if (busy_run != 0) begin
            chk("busy_len", busy_run, 3);
            busy_run = 0;
         end
         if (rd_chk) begin
            if (rd_q.size() == 0) chk("rd_queue_empty", 1, 0);
            else chk($sformatf("rd[%0d]", rd_addr), rd_data, rd_q.pop_front());
         end
      end
   end

   task automatic read_check(input logic [7:0] a);
      rd_addr = a;
      rd_chk  = 1'b1;
      rd_q.push_back(ref_mem[a]);
      tick(1);
      rd_chk  = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      we        = 1'b1;
      address_w = a;
      data_w    = d;
      tick(1);
      we        = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic do_swap(input logic [7:0] a, input logic [7:0] b);
      int c;
      c         = cyc;
      swap_req  = 1'b1;
      address_A = a;
      address_B = b;
      tick(1);
      swap_req  = 1'b0;
      address_A = 8'($urandom);
      address_B = 8'($urandom);
      model_swap(a, b);
      done_q.push_back(c + 4);
      tick(3);
   endtask

   task automatic hard_reset();
      reset_n = 1'b0;
      model_clear();
      done_q.delete();
      tick(2);
      reset_n = 1'b1;
      tick(1);
   endtask

   initial begin
      int c;
      n_pass = 0; n_total = 0; cyc = 0; busy_run = 0;
      rd_chk = 1'b0; we = 1'b0; address_w = '0; data_w = '0; rd_addr = '0;
      swap_req = 1'b0; address_A = '0; address_B = '0;
      reset_n = 1'b0;
      model_clear();
      tick(2);
      chk("reset_busy", swap_busy, 0);
      chk("reset_wr_ready", wr_ready, 1);
      chk("reset_done", swap_done, 0);
      reset_n = 1'b1;
      tick(1);
      read_check(8'd0);
      read_check(8'd255);

      // Reset while in LOAD, MOVE and STORE
      for (int p = 1; p <= 3; p++) begin
         do_write(8'd22, 8'h16);
         do_write(8'd28, 8'h1C);
         swap_req = 1'b1; address_A = 8'd22; address_B = 8'd28;
         tick(1);
         swap_req = 1'b0;
         tick(p - 1);
         #2 reset_n = 1'b0;
         model_clear();
         #3;
         chk("midreset_busy", swap_busy, 0);
         chk("midreset_wr_ready", wr_ready, 1);
         tick(1);
         reset_n = 1'b1;
         tick(1);
         read_check(8'd22);
         read_check(8'd28);
      end

      // Basic swap
      for (int i = 20; i < 30; i++) do_write(8'(i), 8'(i));
      do_swap(8'd22, 8'd28);
      for (int i = 20; i < 30; i++) read_check(8'(i));

      // Write during busy is dropped
      for (int i = 20; i < 30; i++) do_write(8'(i), 8'(i));
      c = cyc;
      swap_req = 1'b1; address_A = 8'd22; address_B = 8'd28;
      tick(1);
      swap_req = 1'b0; address_A = 8'd1; address_B = 8'd2;
      chk("busy_wr_ready", wr_ready, 0);
      we = 1'b1; address_w = 8'd22; data_w = 8'hAA;
      tick(2);
      we = 1'b0;
      model_swap(8'd22, 8'd28);
      done_q.push_back(c + 4);
      tick(1);
      read_check(8'd22);
      read_check(8'd28);

      // Same-cycle write and swap request
      do_write(8'd6, 8'h66);
      c = cyc;
      we = 1'b1; address_w = 8'd5; data_w = 8'h55;
      swap_req = 1'b1; address_A = 8'd5; address_B = 8'd6;
      ref_mem[5] = 8'h55;
      tick(1);
      we = 1'b0; swap_req = 1'b0;
      model_swap(8'd5, 8'd6);
      done_q.push_back(c + 4);
      tick(3);
      read_check(8'd5);
      read_check(8'd6);

      // A == B
      do_write(8'd40, 8'h3C);
      do_swap(8'd40, 8'd40);
      read_check(8'd40);

      // Randomized writes and swaps
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 3) == 0) do_swap(8'($urandom), 8'($urandom));
         else do_write(8'($urandom), 8'($urandom));
      end
      for (int i = 0; i < 256; i++) read_check(8'(i));

      // Back-to-back swaps with swap_req held
      hard_reset();
      do_write(8'd70, 8'hA7);
      do_write(8'd71, 8'hB8);
      c = cyc;
      swap_req = 1'b1; address_A = 8'd70; address_B = 8'd71;
      for (int k = 0; k < 5; k++) begin
         done_q.push_back(c + 4 + 4 * k);
         model_swap(8'd70, 8'd71);
      end
      tick(17);
      swap_req = 1'b0;
      tick(3);
      read_check(8'd70);
      read_check(8'd71);
`ifdef SWAP_CNT_EN
      chk("swap_count", swap_count, 32'(model_cnt));
`endif

      tick(4);
      chk("done_queue_drained", done_q.size(), 0);
      chk("rd_queue_drained", rd_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
